inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Boot-time program loader upstream of the rvseed core's instruction memory; the synthesizable counterpart of the bench-side $readmemh image load.
- Accepts a byte stream over a valid/ready handshake: 16-bit word-count header, then little-endian 32-bit instruction words.
- Writes each assembled word into instruction memory.
- Holds the core in reset until the image is complete, then releases it after a fixed delay.

Parameters:
- CPU_WIDTH, 32, instruction word width (fixed at 32; byte assembly assumes 4 bytes/word)
- ADDR_WIDTH, 10, instruction memory word-address width; capacity 2^ADDR_WIDTH words
- RELEASE_DLY, 4, cycles between last memory write and core_rst_n rising (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse: abort anything in progress, re-enter header phase
- byte_vld  in  1  stream byte valid
- byte_data  in  8  stream byte
- byte_rdy  out  1  loader can accept byte (transfer = byte_vld & byte_rdy)
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address of write
- mem_wdata  out  CPU_WIDTH  assembled instruction word
- core_rst_n  out  1  active-low reset to core; 0 while loading
- load_busy  out  1  state in HDR_LO/HDR_HI/DATA/CSUM
- load_done  out  1  image loaded, core running
- load_err  out  1  sticky error (bad length / checksum)
- word_cnt  out  ADDR_WIDTH+1  words written in current load

Behaviour:
- Reset values: state HDR_LO; byte_rdy=1; mem_we=0; mem_addr=0; mem_wdata=0; core_rst_n=0; load_busy=1; load_done=0; load_err=0; word_cnt=0.
- States: HDR_LO, HDR_HI, DATA, CSUM (macro only), RELEASE, RUN, ERROR.
- byte_rdy = 1 in HDR_LO/HDR_HI/DATA/CSUM and load_start=0; else 0 (load_start is the only combinational input to byte_rdy).
- HDR_LO: accepted byte -> len[7:0], go to HDR_HI. HDR_HI: accepted byte -> len[15:8], then:
  - len == 0: go to RELEASE (CSUM if macro).
  - len > 2^ADDR_WIDTH: load_err=1, go to ERROR.
  - otherwise go to DATA, byte index=0, mem_addr=0, word_cnt=0.
- DATA: bytes fill mem_wdata LE (byte0 -> [7:0] ... byte3 -> [31:24]).
  - On the 4th byte: mem_we=1 the next cycle for exactly one cycle, with mem_addr=word_cnt and the full word.
  - mem_addr/word_cnt increment after the write.
  - The write strobe does not stall the stream: byte_rdy stays 1, back-to-back bytes at 1/cycle are legal.
- After word len is written: go to RELEASE (CSUM if macro). The last mem_we pulse and the RELEASE entry occur in the same cycle.
- RELEASE: counter loads RELEASE_DLY and decrements each cycle; at 0: core_rst_n=1, load_done=1, load_busy=0, go to RUN.
- RUN: idle; byte_rdy=0; outputs stable. load_start -> next cycle core_rst_n=0, load_done=0, word_cnt=0, state HDR_LO.
- ERROR: core_rst_n=0, byte_rdy=0, load_err=1 held. Only load_start or rst leaves ERROR; load_start clears load_err and goes to HDR_LO.
- load_start in any busy state: partial word discarded, no mem_we issued for it, restart at HDR_LO. A byte presented the same cycle is not accepted.
- mem_addr wrap: never occurs; length check bounds it. Max load (len = 2^ADDR_WIDTH) ends with word_cnt = 2^ADDR_WIDTH.
- rst mid-load: immediate return to reset values; memory contents undefined for the partial image.

Optional Feature:
- Macro INST_LOADER_CSUM_EN.
- Defined:
  - CSUM state follows the last data word (or the header when len = 0).
  - Running XOR over all header and data bytes is compared with one trailing byte.
  - Match -> RELEASE; mismatch -> load_err=1, ERROR, core stays in reset.
  - Checksum register cleared on rst and load_start.
- Undefined: no CSUM state, no checksum logic; DATA/HDR_HI go directly to RELEASE.

Test Plan:
- Stream 02 00 | 13 05 10 00 | 93 05 20 00, byte_vld held high -> mem_we pulses with addr 0 data 0x00100513, then addr 1 data 0x00200593. core_rst_n rises RELEASE_DLY=4 cycles after the 2nd write; load_done=1; word_cnt=2.
- Header 00 00 -> no mem_we; RELEASE then RUN, core_rst_n=1 after 4 cycles.
- Header 01 04 (len 1025, ADDR_WIDTH=10) -> load_err=1, ERROR, byte_rdy=0, core_rst_n=0. Then load_start -> load_err=0, state HDR_LO.
- Load 1 word, send 2 bytes of the next load, pulse load_start -> no mem_we for the partial word. A fresh 01 00 + 4-byte image writes addr 0 correctly.
- Random byte_vld gaps across a 16-word image -> all 16 words written correctly, in order; byte_rdy=0 in RUN.
- With INST_LOADER_CSUM_EN: 01 00 78 56 34 12 + checksum 0x09 -> RUN. Same image + checksum 0x08 -> load_err=1, core_rst_n stays 0.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream handshake into the instruction loader.
// Transfer happens when byte_vld and byte_rdy are both high on a rising clock edge.
interface inst_loader_if;
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       byte_rdy;

  modport master (output byte_vld, output byte_data, input byte_rdy);
  modport slave  (input byte_vld, input byte_data, output byte_rdy);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: boot-time byte-stream program loader for the rvseed instruction memory.
// Define INST_LOADER_CSUM_EN to require a trailing XOR checksum byte after each image.
module inst_loader #(
  parameter int unsigned CPU_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  inst_loader_if.slave          byte_if,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0]  mem_wdata,
  output logic                  core_rst_n,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int unsigned MaxLen = 32'd1 << ADDR_WIDTH;
  localparam int unsigned DlyW   = $clog2(RELEASE_DLY + 1);
  localparam logic [DlyW-1:0] RelDly = DlyW'(RELEASE_DLY);

  typedef enum logic [2:0] {
    StHdrLo,
    StHdrHi,
    StData,
`ifdef INST_LOADER_CSUM_EN
    StCsum,
`endif
    StRelease,
    StRun,
    StError
  } state_e;

  state_e            state;
  state_e            post_state;
  logic [15:0]       len;
  logic [15:0]       new_len;
  logic [1:0]        byte_idx;
  logic [DlyW-1:0]   rel_cnt;
  logic              busy;
  logic              xfer;
  logic              last_word;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    busy = 1'b0;
    case (state)
      StHdrLo, StHdrHi, StData: busy = 1'b1;
`ifdef INST_LOADER_CSUM_EN
      StCsum:                   busy = 1'b1;
`endif
      default:                  busy = 1'b0;
    endcase
  end

  // Where the image goes once the header (len 0) or the last data word is in.
  always_comb begin
`ifdef INST_LOADER_CSUM_EN
    post_state = StCsum;
`else
    post_state = StRelease;
`endif
  end

  // load_start blocks acceptance so a byte presented alongside it is never consumed.
  assign byte_if.byte_rdy = busy & ~load_start;
  assign load_busy        = busy;
  assign xfer             = byte_if.byte_vld & byte_if.byte_rdy;
  assign new_len          = {byte_if.byte_data, len[7:0]};
  // word_cnt has already advanced past the previous write by the time a 4th byte lands.
  assign last_word        = (32'(word_cnt) + 32'd1) == 32'(len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StHdrLo;
      len        <= '0;
      byte_idx   <= '0;
      rel_cnt    <= RelDly;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_cnt   <= '0;
`ifdef INST_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
        word_cnt <= word_cnt + (ADDR_WIDTH+1)'(1);
      end
      if (state != StRelease) rel_cnt <= RelDly;
`ifdef INST_LOADER_CSUM_EN
      if (xfer && state != StCsum) csum <= csum ^ byte_if.byte_data;
`endif
      if (load_start) begin
        state      <= StHdrLo;
        mem_we     <= 1'b0;
        byte_idx   <= '0;
        mem_addr   <= '0;
        word_cnt   <= '0;
        core_rst_n <= 1'b0;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
`ifdef INST_LOADER_CSUM_EN
        csum       <= '0;
`endif
      end else begin
        unique case (state)
          StHdrLo: begin
            if (xfer) begin
              len[7:0] <= byte_if.byte_data;
              state    <= StHdrHi;
            end
          end
          StHdrHi: begin
            if (xfer) begin
              len[15:8] <= byte_if.byte_data;
              if (new_len == 16'd0) begin
                state <= post_state;
              end else if (32'(new_len) > MaxLen) begin
                load_err <= 1'b1;
                state    <= StError;
              end else begin
                state    <= StData;
                byte_idx <= '0;
                mem_addr <= '0;
                word_cnt <= '0;
              end
            end
          end
          StData: begin
            if (xfer) begin
              mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_if.byte_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                mem_we <= 1'b1;
                if (last_word) state <= post_state;
              end
            end
          end
`ifdef INST_LOADER_CSUM_EN
          StCsum: begin
            if (xfer) begin
              if (byte_if.byte_data == csum) begin
                state <= StRelease;
              end else begin
                load_err <= 1'b1;
                state    <= StError;
              end
            end
          end
`endif
          StRelease: begin
            rel_cnt <= rel_cnt - DlyW'(1);
            if (rel_cnt == DlyW'(1)) begin
              state      <= StRun;
              core_rst_n <= 1'b1;
              load_done  <= 1'b1;
            end
          end
          StRun, StError: begin
          end
          default: state <= StHdrLo;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: byte-count reference model plus literal pins.
module tb_inst_loader;
  localparam int AW  = 10;
  localparam int DLY = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_start = 1'b0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            core_rst_n;
  logic            load_busy;
  logic            load_done;
  logic            load_err;
  logic [AW:0]     word_cnt;

  inst_loader_if bif();

  inst_loader #(
    .CPU_WIDTH  (32),
    .ADDR_WIDTH (AW),
    .RELEASE_DLY(DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .byte_if   (bif.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst_n(core_rst_n),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks bytes accepted in the current load and derives outputs from counts.
  int          m_acc = 0;
  int          m_len = 0;
  int          m_rel = -1;
  bit          m_err = 0;
  bit          m_run = 0;
  bit          m_we  = 0;
  int          m_wc  = 0;
  int          m_waddr = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_wdata = '0;
  logic [7:0]  m_csum = '0;

  function automatic bit m_loading();
    return !m_err && !m_run && (m_rel < 0);
  endfunction

  task automatic model_clear();
    m_acc = 0; m_len = 0; m_rel = -1; m_err = 0; m_run = 0;
    m_we = 0; m_wc = 0; m_csum = '0;
  endtask

  task automatic model_post();
`ifndef INST_LOADER_CSUM_EN
    m_rel = DLY;
`endif
  endtask

  task automatic model_step();
    bit         ld;
    logic [7:0] b;
    int         idx;
    if (rst || load_start) begin
      model_clear();
      return;
    end
    ld = m_loading();
    if (m_we) begin m_wc++; m_we = 0; end
    if (m_rel >= 0) begin
      m_rel--;
      if (m_rel == 0) begin m_run = 1; m_rel = -1; end
    end
    if (ld && bif.byte_vld) begin
      b = bif.byte_data;
      m_acc++;
      if (m_acc == 1) begin
        m_len = int'(b);
      end else if (m_acc == 2) begin
        m_len = m_len + (int'(b) << 8);
        if (m_len == 0) model_post();
        else if (m_len > (1 << AW)) m_err = 1;
      end else if (m_acc <= 2 + 4 * m_len) begin
        idx = m_acc - 3;
        m_word[8*(idx%4) +: 8] = b;
        if (idx % 4 == 3) begin
          m_we = 1; m_waddr = idx / 4; m_wdata = m_word;
          if (idx / 4 == m_len - 1) model_post();
        end
      end else begin
        if (b == m_csum) m_rel = DLY;
        else m_err = 1;
      end
      if (m_acc <= 2 + 4 * m_len) m_csum = m_csum ^ b;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // DUT write log and release timing, used by the literal pins.
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc = 0;
  int          rise_cyc = 0;
  int          last_acc_cyc = 0;
  logic        prev_crn = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("byte_rdy",   64'(bif.byte_rdy), 64'(m_loading() && !load_start));
      check("mem_we",     64'(mem_we),       64'(m_we));
      check("core_rst_n", 64'(core_rst_n),   64'(m_run));
      check("load_done",  64'(load_done),    64'(m_run));
      check("load_busy",  64'(load_busy),    64'(m_loading()));
      check("load_err",   64'(load_err),     64'(m_err));
      check("word_cnt",   64'(word_cnt),     64'(m_wc));
      if (m_we) begin
        check("mem_addr",  64'(mem_addr),  64'(m_waddr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      if (mem_we === 1'b1) begin
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(mem_wdata);
        wr_cyc = cyc;
      end
      if (core_rst_n === 1'b1 && prev_crn !== 1'b1) rise_cyc = cyc;
    end
    prev_crn = core_rst_n;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    bif.byte_vld  = 1'b1;
    bif.byte_data = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bif.byte_rdy === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    last_acc_cyc  = cyc;
    bif.byte_vld  = 1'b0;
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL send_byte: byte %0h not accepted, byte_rdy stuck at %0b", b, bif.byte_rdy);
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    load_start = 1'b1;
    if (with_byte) begin bif.byte_vld = 1'b1; bif.byte_data = 8'hAA; end
    @(posedge clk); #1;
    load_start   = 1'b0;
    bif.byte_vld = 1'b0;
  endtask

  logic [31:0] img[$];

  task automatic send_image(input bit gaps);
    logic [7:0] cs;
    logic [7:0] b;
    int         n;
    n  = img.size();
    cs = 8'(n) ^ 8'(n >> 8);
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    foreach (img[w]) begin
      for (int k = 0; k < 4; k++) begin
        b  = img[w][8*k +: 8];
        cs = cs ^ b;
        if (gaps) tick($urandom_range(0, 2));
        send_byte(b);
      end
    end
`ifdef INST_LOADER_CSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_run(input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: load_done got %0b, expected 1 within %0d cycles", tag, load_done, budget);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, ".byte_rdy"},   64'(bif.byte_rdy), 64'd1);
    check({tag, ".mem_we"},     64'(mem_we),       64'd0);
    check({tag, ".mem_addr"},   64'(mem_addr),     64'd0);
    check({tag, ".mem_wdata"},  64'(mem_wdata),    64'd0);
    check({tag, ".core_rst_n"}, 64'(core_rst_n),   64'd0);
    check({tag, ".load_busy"},  64'(load_busy),    64'd1);
    check({tag, ".load_done"},  64'(load_done),    64'd0);
    check({tag, ".load_err"},   64'(load_err),     64'd0);
    check({tag, ".word_cnt"},   64'(word_cnt),     64'd0);
  endtask

  initial begin
    bif.byte_vld  = 1'b0;
    bif.byte_data = 8'h00;
    tick(2);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word image, stream held back to back.
    img = '{32'h0010_0513, 32'h0020_0593};
    send_image(1'b0);
    wait_run(40, "two_word");
    check("two_word.nwr",   64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("two_word.a0", 64'(wr_addr[0]), 64'd0);
      check("two_word.d0", 64'(wr_data[0]), 64'h0010_0513);
      check("two_word.a1", 64'(wr_addr[1]), 64'd1);
      check("two_word.d1", 64'(wr_data[1]), 64'h0020_0593);
    end
`ifndef INST_LOADER_CSUM_EN
    check("two_word.dly", 64'(rise_cyc - wr_cyc), 64'd4);
`endif
    tick(3);
    check("two_word.wc",      64'(word_cnt),     64'd2);
    check("run.byte_rdy",     64'(bif.byte_rdy), 64'd0);
    check("run.core_rst_n",   64'(core_rst_n),   64'd1);

    // Zero-length image.
    pulse_start(1'b0);
    wr_addr.delete(); wr_data.delete();
    img.delete();
    send_image(1'b0);
    wait_run(40, "len0");
`ifndef INST_LOADER_CSUM_EN
    check("len0.dly", 64'(rise_cyc - last_acc_cyc), 64'd4);
`endif
    check("len0.nwr", 64'(wr_addr.size()), 64'd0);

    // Oversized header 01 04 (1025 words).
    pulse_start(1'b0);
    send_byte(8'h01);
    send_byte(8'h04);
    tick(3);
    @(negedge clk);
    check("err.load_err",   64'(load_err),     64'd1);
    check("err.byte_rdy",   64'(bif.byte_rdy), 64'd0);
    check("err.core_rst_n", 64'(core_rst_n),   64'd0);
    @(posedge clk); #1;
    pulse_start(1'b0);
    @(negedge clk);
    check("err_clr.load_err",  64'(load_err),  64'd0);
    check("err_clr.load_busy", 64'(load_busy), 64'd1);
    @(posedge clk); #1;

    // Abort mid-word, byte presented with load_start, then a fresh image.
    img = '{32'h1122_3344};
    send_image(1'b0);
    wait_run(40, "abort.first");
    pulse_start(1'b0);
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h44); send_byte(8'h33);
    pulse_start(1'b1);
    img = '{32'hDEAD_BEEF};
    send_image(1'b0);
    wait_run(40, "abort.fresh");
    check("abort.nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      check("abort.a0", 64'(wr_addr[0]), 64'd0);
      check("abort.d0", 64'(wr_data[0]), 64'hDEAD_BEEF);
    end

    // 16 words with random gaps.
    pulse_start(1'b0);
    wr_addr.delete(); wr_data.delete();
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back((32'h0102_0304 * 32'(i + 1)) ^ 32'hA5A5_0000);
    send_image(1'b1);
    wait_run(400, "gaps");
    check("gaps.nwr", 64'(wr_addr.size()), 64'd16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("gaps.addr", 64'(wr_addr[i]), 64'(i));
        check("gaps.data", 64'(wr_data[i]), 64'(img[i]));
      end
    end
    check("gaps.byte_rdy", 64'(bif.byte_rdy), 64'd0);

    // Reset in the middle of a load.
    pulse_start(1'b0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    rst = 1'b1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    img = '{32'hCAFE_F00D};
    send_image(1'b0);
    wait_run(40, "midrst.reload");
    check("midrst.wc", 64'(word_cnt), 64'd1);

    // Maximum-length image.
    pulse_start(1'b0);
    wr_addr.delete(); wr_data.delete();
    img.delete();
    for (int i = 0; i < (1 << AW); i++) img.push_back(32'h1357_0000 + 32'(i) * 32'h0001_0001);
    send_image(1'b0);
    wait_run(5000, "maxlen");
    check("maxlen.nwr", 64'(wr_addr.size()), 64'd1024);
    check("maxlen.wc",  64'(word_cnt),       64'd1024);

`ifdef INST_LOADER_CSUM_EN
    // Checksum literal: 01^00^78^56^34^12 = 09.
    pulse_start(1'b0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h09);
    wait_run(40, "csum.good");
    pulse_start(1'b0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h08);
    tick(8);
    @(negedge clk);
    check("csum.bad.err",        64'(load_err),   64'd1);
    check("csum.bad.core_rst_n", 64'(core_rst_n), 64'd0);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
